// File: rtl/pool_pkg.sv
// Shared types for the streaming pooling engine: reduction mode and the
// observable window state derived from the beat counter and output register.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: running max or sum over a window, with the final beat
// folded in combinationally so the result is ready on the completing beat.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         first,
  input  logic                         last,
  input  pool_mode_e                   mode,
  input  logic signed [DATA_WIDTH-1:0] elem,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam int ACC_W = DATA_WIDTH + CNT_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] elem_x;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] mx;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] nxt;

  always_comb begin
    elem_x  = ACC_W'(elem);
    sum     = acc + elem_x;
    // ties keep the accumulated value
    mx      = (elem_x > acc) ? elem_x : acc;
    shifted = sum >>> CNT_W;
    if (first)
      nxt = elem_x;
    else if (mode == POOL_AVG)
      nxt = sum;
    else
      nxt = mx;
    result = DATA_WIDTH'((mode == POOL_AVG) ? shifted : mx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (en && !last)
      acc <= nxt;
  end

endmodule

// File: rtl/pool_stream.sv
// Streaming pooling engine top: beat counter, window mode latch, valid/ready
// handshake and the output register shared by all lanes.
module pool_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int POOL_SIZE  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode_avg,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           busy
);

  localparam int CNT_W = $clog2(POOL_SIZE);
  localparam int ACC_W = DATA_WIDTH + CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

  logic [CNT_W-1:0]               cnt;
  pool_mode_e                     mode_q;
  pool_mode_e                     mode_eff;
  state_t                         state;
  logic                           accept;
  logic                           first;
  logic                           last;
  logic                           lane_en;
  logic [CHANNELS*DATA_WIDTH-1:0] lane_res;

  always_comb begin
    first    = (cnt == '0);
    last     = (cnt == CNT_LAST);
    in_ready = !last || !out_valid || out_ready;
    accept   = in_valid && in_ready;
    lane_en  = accept && !clear;
    mode_eff = first ? pool_mode_e'(mode_avg) : mode_q;
    if (!first)
      state = ACCUM;
    else if (out_valid)
      state = HOLD;
    else
      state = IDLE;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mode_q    <= POOL_MAX;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= cnt + CNT_W'(1);
        if (first)
          mode_q <= pool_mode_e'(mode_avg);
      end
      // a completing beat reloads the register even when the old result leaves
      if (accept && last) begin
        out_valid <= 1'b1;
        out_data  <= lane_res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_W     (ACC_W - DATA_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (lane_en),
      .first (first),
      .last  (last),
      .mode  (mode_eff),
      .elem  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .result(lane_res[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream: table of windows with hand-computed results
// plus sequences for backpressure, clear, mid-window mode change and reset.
module tb_pool_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_avg = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic             mode;
    logic [3:0][31:0] beats;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [4];

  pool_stream #(.DATA_WIDTH(8), .CHANNELS(4), .POOL_SIZE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_avg (mode_avg),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic m);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode_avg = m;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;

    vecs[0].mode = 1'b0;
    vecs[0].beats[0] = pk(5, -1, 0, -128);
    vecs[0].beats[1] = pk(-3, -2, 0, -128);
    vecs[0].beats[2] = pk(127, -3, 0, -128);
    vecs[0].beats[3] = pk(-128, -4, 0, -127);
    vecs[0].exp      = pk(127, -1, 0, -127);

    vecs[1].mode = 1'b1;
    vecs[1].beats[0] = pk(10, -1, -128, 127);
    vecs[1].beats[1] = pk(20, -2, -128, 127);
    vecs[1].beats[2] = pk(30, -2, -128, 127);
    vecs[1].beats[3] = pk(41, -2, -128, 127);
    vecs[1].exp      = pk(25, -2, -128, 127);

    vecs[2].mode = 1'b0;
    vecs[2].beats[0] = pk(3, -5, 1, 100);
    vecs[2].beats[1] = pk(3, 7, 2, -100);
    vecs[2].beats[2] = pk(3, 7, 3, 50);
    vecs[2].beats[3] = pk(3, -6, 4, 99);
    vecs[2].exp      = pk(3, 7, 4, 100);

    vecs[3].mode = 1'b1;
    vecs[3].beats[0] = pk(1, -1, 2, -3);
    vecs[3].beats[1] = pk(1, 0, 2, -3);
    vecs[3].beats[2] = pk(1, 0, 2, -3);
    vecs[3].beats[3] = pk(0, 0, 2, -4);
    vecs[3].exp      = pk(0, -1, 2, -4);

    // reset
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // table of windows, sustained back to back with out_ready high
    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < 3; b++) push(vecs[v].beats[b], vecs[v].mode);
      chk($sformatf("v%0d_no_early_valid", v), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_busy_mid", v), 32'(busy), 32'd1);
      push(vecs[v].beats[3], vecs[v].mode);
      chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", v), out_data, vecs[v].exp);
    end
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // backpressure: completing beat waits, then lands with no bubble
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) push(vecs[0].beats[b], 1'b0);
    chk("bp_first_data", out_data, vecs[0].exp);
    for (int b = 0; b < 3; b++) push(vecs[2].beats[b], 1'b0);
    chk("bp_in_ready_3beats", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = vecs[2].beats[3];
    held = out_data;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_valid", 32'(out_valid), 32'd1);
    chk("bp_stall_data", out_data, held);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_nobubble_valid", 32'(out_valid), 32'd1);
    chk("bp_new_data", out_data, vecs[2].exp);
    @(posedge clk);
    #1;
    chk("bp_consumed", 32'(out_valid), 32'd0);

    // clear aborts a partial window
    push(pk(100, 100, 100, 100), 1'b0);
    push(pk(90, 90, 90, 90), 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    for (int b = 1; b <= 3; b++) push(pk(b, b, b, b), 1'b0);
    chk("clr_no_result", 32'(out_valid), 32'd0);
    push(pk(4, 4, 4, 4), 1'b0);
    chk("clr_result_valid", 32'(out_valid), 32'd1);
    chk("clr_result_data", out_data, pk(4, 4, 4, 4));
    @(posedge clk);
    #1;

    // mode_avg change mid-window is ignored
    push(vecs[0].beats[0], 1'b0);
    push(vecs[0].beats[1], 1'b0);
    push(vecs[0].beats[2], 1'b1);
    push(vecs[0].beats[3], 1'b1);
    chk("mode_latched_data", out_data, vecs[0].exp);
    @(posedge clk);
    #1;

    // async reset in HOLD with a partial window pending
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) push(vecs[2].beats[b], 1'b0);
    push(vecs[1].beats[0], 1'b1);
    push(vecs[1].beats[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) push(vecs[1].beats[b], 1'b1);
    chk("arst_fresh_valid", 32'(out_valid), 32'd1);
    chk("arst_fresh_data", out_data, vecs[1].exp);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming, parametrised pooling engine for the CNN datapath, placed between the requantised convolution output and the feature-map write-back buffer. It accepts one element per channel per beat over a valid/ready handshake, reduces each group of POOL_SIZE consecutive beats to one result per channel, and supports max or average reduction selected per window. It replaces fixed 2x2, single-lane, always-ready pooling with multi-channel lanes, backpressure and an abort path.

## Interface
- DATA_WIDTH, 8: signed element width, input and output.
- CHANNELS, 4: parallel lanes; each beat carries one element per lane.
- POOL_SIZE, 4: beats per window; power of two, ≥2.
- Derived localparams: CNT_W = $clog2(POOL_SIZE); ACC_W = DATA_WIDTH + CNT_W.

Ports:
- clk  in  1  clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode_avg  in  1  0 = max, 1 = average; sampled on the first beat of each window.
- clear  in  1  synchronous abort of partial window and pending output.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  CHANNELS*DATA_WIDTH  lane c in bits [c*DATA_WIDTH +: DATA_WIDTH], signed.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  CHANNELS*DATA_WIDTH  per-lane result, same packing.
- busy  out  1  high when beat counter ≠ 0 or out_valid.

## Operation
- Beat counter cnt (CNT_W bits) counts accepted beats within a window, 0..POOL_SIZE-1, wraps to 0 on the last beat.
- First beat (cnt==0): latch mode_avg into mode_q; each lane loads its accumulator with the sign-extended element. mode_avg changes mid-window are ignored.
- Later beats: max mode, acc = signed max(acc, elem) (ties keep acc); avg mode, acc = acc + sign-extended elem in ACC_W bits (cannot overflow).
- Last beat (cnt==POOL_SIZE-1): lane result combines the final beat with acc; max → result directly; avg → (sum) >>> CNT_W, arithmetic shift, rounding toward −inf, always fits DATA_WIDTH. Result loads out_data, out_valid set.
- Output register: out_data held stable while out_valid && !out_ready. out_valid clears on handshake unless a new result loads the same cycle (then it stays 1 with new data).
- in_ready = (cnt != POOL_SIZE-1) || !out_valid || out_ready; only the window-completing beat waits for output space.
- State machine (state_t): IDLE (cnt==0, !out_valid), ACCUM (0<cnt), HOLD (out_valid, cnt==0). ACCUM and out_valid may coexist; state is derived from cnt and out_valid, not stored separately.
- clear: highest priority after reset; next cycle cnt=0, out_valid=0, accumulators don't-care; a beat presented in the clear cycle is accepted handshake-wise but discarded; a result handshake in that cycle counts as consumed.

## Timing
- Reset (async assert): out_valid=0, out_data=0, cnt=0, mode_q=0, busy=0; in_ready=1 immediately after rst_n rises.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: one beat per cycle sustained, one result every POOL_SIZE cycles, with out_ready=1.
- Simultaneous consume of old result and completion of new window: no bubble, out_valid stays 1.
- rst_n asserted mid-window or mid-HOLD: all state returns to reset values asynchronously; partial data is lost.
- in_ready and busy are combinational from registered state and out_ready only; no path from in_valid.

## Structure
- Package pool_pkg: pool_mode_e {POOL_MAX, POOL_AVG}; state_t {IDLE, ACCUM, HOLD} for debug/assertions.
- Sub-module pool_lane (one per channel, generate loop): accumulator register, max/add datapath, final shift; inputs first/last/enable/mode; output DATA_WIDTH result.
- Top holds the counter, mode_q, handshake logic and output register.

## Test plan
- Reset: hold rst_n=0 → out_valid=0, out_data=0, busy=0; release → in_ready=1.
- Max, defaults: lane0 beats 5,−3,127,−128 → 127; lane1 −1,−2,−3,−4 → −1; out_valid one cycle after beat 4.
- Avg: lane0 10,20,30,41 → 25; lane1 −1,−2,−2,−2 → −2; lane2 −128×4 → −128; lane3 127×4 → 127.
- Backpressure: out_ready=0 after a result; next window's 3 beats accepted, 4th sees in_ready=0 and out_data stays stable; out_ready=1 → 4th accepted same cycle, new result next cycle with no bubble.
- clear after 2 beats of a window, then 4 beats 1,2,3,4 in max → result 4; no result emitted for the aborted beats.
- mode_avg toggled 0→1 at beat 3 → window reduced as max; rst_n pulsed at beat 2 → out_valid=0, busy=0 at once, next 4 beats form a fresh window.
